// File: rtl/rand_step_display.sv
// Debounced step button for the LFSR: one step pulse per press, then capture of the new byte shown on two hex digits.
// Optional RAND_STUCK_DETECT_EN adds a sticky 'stuck' flag for zero or repeated captures.
module rand_step_display #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter bit SEG_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    input  logic [7:0] random_in,
    output logic       step_en,
    output logic [7:0] held,
    output logic       valid,
    output logic [7:0] sample_cnt,
    output logic [6:0] seg0,
    output logic [6:0] seg1
`ifdef RAND_STUCK_DETECT_EN
    ,
    output logic       stuck
`endif
);

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STEP, CAPTURE, WAIT_REL} state_t;

    logic        r_s1, r_s, r_db;
    logic [15:0] r_db_cnt;
    state_t      r_state, w_next;
    logic [7:0]  r_held, r_cnt;
    logic        r_valid;
    logic [6:0]  w_seg0_ah, w_seg1_ah;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s  <= 1'b0;
        end else begin
            r_s1 <= btn_in;
            r_s  <= r_s1;
        end
    end

    // db only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db     <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_s == r_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db     <= ~r_db;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        step_en = 1'b0;
        case (r_state)
            IDLE:     if (r_db) w_next = STEP;
            STEP:     begin
                step_en = 1'b1;
                w_next  = CAPTURE;
            end
            CAPTURE:  w_next = WAIT_REL;
            WAIT_REL: if (!r_db) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // LFSR advanced at the end of STEP, so its new byte is stable during CAPTURE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (r_state == CAPTURE) begin
            r_held  <= random_in;
            r_cnt   <= r_cnt + 8'd1;
            r_valid <= 1'b1;
        end
    end

`ifdef RAND_STUCK_DETECT_EN
    logic r_stuck;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stuck <= 1'b0;
        else if (r_state == CAPTURE &&
                 (random_in == 8'h00 || (r_valid && random_in == r_held)))
            r_stuck <= 1'b1;
    end
    assign stuck = r_stuck;
`endif

    assign w_seg0_ah  = r_valid ? hex7(r_held[3:0]) : 7'h00;
    assign w_seg1_ah  = r_valid ? hex7(r_held[7:4]) : 7'h00;
    assign seg0       = SEG_ACTIVE_LOW ? ~w_seg0_ah : w_seg0_ah;
    assign seg1       = SEG_ACTIVE_LOW ? ~w_seg1_ah : w_seg1_ah;
    assign held       = r_held;
    assign valid      = r_valid;
    assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_rand_step_display.sv
// Scoreboard bench for rand_step_display with DEBOUNCE_CYCLES=4, active-low segments.
module tb_rand_step_display;

    typedef struct packed {
        logic [7:0] held;
        logic [7:0] cnt;
        logic [6:0] s0;
        logic [6:0] s1;
    } cap_t;

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_in = 1'b0;
    logic [7:0] random_in = 8'h00;
    logic       step_en, valid;
    logic [7:0] held, sample_cnt;
    logic [6:0] seg0, seg1;
`ifdef RAND_STUCK_DETECT_EN
    logic       stuck;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    int   n_steps = 0;
    int   exp_cnt = 0;
    cap_t q[$];

    always #5 clk = ~clk;

    rand_step_display #(.DEBOUNCE_CYCLES(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .random_in(random_in),
        .step_en(step_en), .held(held), .valid(valid), .sample_cnt(sample_cnt),
        .seg0(seg0), .seg1(seg1)
`ifdef RAND_STUCK_DETECT_EN
        , .stuck(stuck)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_cap(input logic [7:0] r);
        cap_t c;
        exp_cnt++;
        c.held = r;
        c.cnt  = exp_cnt[7:0];
        c.s0   = ~HEX[r[3:0]];
        c.s1   = ~HEX[r[7:4]];
        q.push_back(c);
    endtask

    task automatic press(input logic [7:0] r, input int hold);
        random_in = r;
        btn_in = 1'b1;
        repeat (hold) @(negedge clk);
        btn_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Monitor: a step pulse means a capture lands two edges later
    initial begin
        cap_t c;
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (step_en && prev) chk("step_width", 32'd2, 32'd1);
            prev = step_en;
            if (step_en && rst_n) begin
                n_steps++;
                @(negedge clk);
                prev = step_en;
                if (step_en) chk("step_width", 32'd2, 32'd1);
                @(negedge clk);
                prev = step_en;
                if (rst_n) begin
                    if (q.size() == 0) begin
                        chk("unexpected_capture", 32'(held), 32'hFFFF_FFFF);
                    end else begin
                        c = q.pop_front();
                        chk("cap_held", 32'(held), 32'(c.held));
                        chk("cap_cnt", 32'(sample_cnt), 32'(c.cnt));
                        chk("cap_valid", 32'(valid), 32'd1);
                        chk("cap_seg0", 32'(seg0), 32'(c.s0));
                        chk("cap_seg1", 32'(seg1), 32'(c.s1));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        // reset values
        #27;
        chk("rst_step_en", 32'(step_en), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_cnt", 32'(sample_cnt), 32'd0);
        chk("rst_held", 32'(held), 32'd0);
        chk("rst_seg0", 32'(seg0), 32'h7F);
        chk("rst_seg1", 32'(seg1), 32'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 3-cycle glitch is shorter than D=4
        btn_in = 1'b1;
        repeat (3) @(negedge clk);
        btn_in = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_steps", 32'(n_steps), 32'd0);
        chk("glitch_cnt", 32'(sample_cnt), 32'd0);
        chk("glitch_valid", 32'(valid), 32'd0);
        chk("glitch_seg0", 32'(seg0), 32'h7F);

        // clean press: step_en first high right after edge k+6
        expect_cap(8'hA5);
        random_in = 8'hA5;
        btn_in = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk("press1_step_timing", 32'(step_en), (i == 7) ? 32'd1 : 32'd0);
        end
        repeat (13) @(negedge clk);
        chk("press1_held", 32'(held), 32'hA5);
        chk("press1_seg0", 32'(seg0), 32'h12);
        chk("press1_seg1", 32'(seg1), 32'h08);
        // bouncy release: 2-cycle toggles for 10 cycles
        for (int i = 0; i < 5; i++) begin
            btn_in = (i % 2 == 1);
            repeat (2) @(negedge clk);
        end
        btn_in = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_steps", 32'(n_steps), 32'd1);

        expect_cap(8'h3C);
        press(8'h3C, 20);
        chk("press2_steps", 32'(n_steps), 32'd2);
        chk("press2_cnt", 32'(sample_cnt), 32'd2);
        chk("press2_held", 32'(held), 32'h3C);
        chk("press2_seg0", 32'(seg0), 32'h46);
        chk("press2_seg1", 32'(seg1), 32'h30);

        // 254 more presses wrap the counter to 0
        for (int i = 0; i < 254; i++) begin
            expect_cap(8'(i + 1));
            press(8'(i + 1), 10);
        end
        chk("wrap_cnt", 32'(sample_cnt), 32'd0);
        chk("wrap_valid", 32'(valid), 32'd1);
        chk("wrap_held", 32'(held), 32'hFE);
        chk("wrap_steps", 32'(n_steps), 32'd256);

        // reset during CAPTURE; button stays held through reset
        random_in = 8'h77;
        btn_in = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!step_en && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_step_seen", 32'(step_en), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_held", 32'(held), 32'd0);
        chk("midrst_cnt", 32'(sample_cnt), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_seg1", 32'(seg1), 32'h7F);
        repeat (3) @(negedge clk);
        exp_cnt = 0;
        random_in = 8'h5A;
        expect_cap(8'h5A);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        btn_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_cnt", 32'(sample_cnt), 32'd1);
        chk("post_rst_held", 32'(held), 32'h5A);

        expect_cap(8'h00);
        press(8'h00, 10);
`ifdef RAND_STUCK_DETECT_EN
        chk("stuck_set", 32'(stuck), 32'd1);
`endif
        expect_cap(8'h11);
        press(8'h11, 10);
        chk("final_cnt", 32'(sample_cnt), 32'd3);
`ifdef RAND_STUCK_DETECT_EN
        chk("stuck_sticky", 32'(stuck), 32'd1);
`endif

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
